multiplicator_arbiter: RTL and testbench

- Shares one fast_multiplicator instance between NUM_REQ requesters.
- Each requester uses a valid/ready request channel (operands in) and a valid/ready response channel (product and overflow out).
- Arbitration is round-robin, with one transaction in flight at a time.
- The block sits between client datapaths and the multiplier core: it drives the core's operand inputs and samples product_out/overflow_out after a fixed latency.

---
 rtl/multiplicator_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_multiplicator_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplicator_arbiter.sv
// -----------------------------------------------------------------------------
// multiplicator_arbiter
//
// Shares a single fast_multiplicator core between NUM_REQ requesters. Each
// requester offers operands on a valid/ready request channel and receives the
// product and overflow flag on a valid/ready response channel. Arbitration is
// round-robin and only one transaction is in flight at any time.
//
// Optional feature (compile-time macro MULT_ARB_GRANT_COUNT_EN):
//   adds grant_count_out, one saturating 16-bit completed-transaction counter
//   per requester, packed like the operand buses.
//
// Parameters:
//   WIDTH       operand width, product is 2*WIDTH
//   NUM_REQ     number of requesters (2..16)
//   MUL_LATENCY edges from operand launch to product sampling (1..15)
//
// Ports:
//   clock, reset_n         rising-edge clock, asynchronous active-low reset
//   req_valid_in           per-requester request valid
//   req_ready_out          per-requester request ready (one-hot or zero)
//   req_multiplicand_in    packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_multiplier_in      packed operands, same packing
//   rsp_valid_out          per-requester response valid (one-hot or zero)
//   rsp_ready_in           per-requester response ready
//   rsp_product_out        registered product shared by all requesters
//   rsp_overflow_out       registered overflow shared by all requesters
//   grant_id_out           index of the current/last granted requester
//   busy_out               high whenever the arbiter is not idle
//   mul_multiplicand_out   operand register driving the core
//   mul_multiplier_out     operand register driving the core
//   mul_product_in         product from the core
//   mul_overflow_in        overflow from the core
//   grant_count_out        (optional) per-requester completion counters
// -----------------------------------------------------------------------------
module multiplicator_arbiter #(
    parameter int WIDTH       = 8,
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid_in,
    output logic [NUM_REQ-1:0]           req_ready_out,
    input  logic [NUM_REQ*WIDTH-1:0]     req_multiplicand_in,
    input  logic [NUM_REQ*WIDTH-1:0]     req_multiplier_in,
    output logic [NUM_REQ-1:0]           rsp_valid_out,
    input  logic [NUM_REQ-1:0]           rsp_ready_in,
    output logic [2*WIDTH-1:0]           rsp_product_out,
    output logic                         rsp_overflow_out,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id_out,
    output logic                         busy_out,
    output logic [WIDTH-1:0]             mul_multiplicand_out,
    output logic [WIDTH-1:0]             mul_multiplier_out,
    input  logic [2*WIDTH-1:0]           mul_product_in,
    input  logic                         mul_overflow_in
`ifdef MULT_ARB_GRANT_COUNT_EN
    ,
    output logic [16*NUM_REQ-1:0]        grant_count_out
`endif
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = 4;
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W-1:0]  ONE_ID   = ID_W'(1);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MUL_LATENCY);
    localparam logic [CNT_W-1:0] LAT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_n_s;
    logic [ID_W-1:0]   rr_ptr_r;
    logic [ID_W-1:0]   grant_id_r;
    logic [CNT_W-1:0]  lat_cnt_r;
    logic [WIDTH-1:0]  mcand_r;
    logic [WIDTH-1:0]  mplier_r;
    logic [2*WIDTH-1:0] product_r;
    logic              overflow_r;

    logic              found_s;
    logic [ID_W-1:0]   grant_s;
    logic [ID_W-1:0]   idx_s;
    logic [NUM_REQ-1:0] req_ready_s;
    logic [NUM_REQ-1:0] rsp_valid_s;
    logic              launch_s;
    logic              sample_s;
    logic              rsp_done_s;

    // Round-robin search: first valid requester at or after rr_ptr_r, wrapping
    // explicitly at NUM_REQ-1 so non-power-of-two sizes never index past the end.
    always_comb begin
        found_s = 1'b0;
        grant_s = '0;
        idx_s   = rr_ptr_r;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_s && req_valid_in[idx_s]) begin
                found_s = 1'b1;
                grant_s = idx_s;
            end else begin
                found_s = found_s;
            end
            if (idx_s == LAST_ID) begin
                idx_s = '0;
            end else begin
                idx_s = idx_s + ONE_ID;
            end
        end
    end

    // Next-state and handshake decode for the IDLE/WAIT/RESPOND controller.
    always_comb begin
        state_n_s   = state_r;
        req_ready_s = '0;
        rsp_valid_s = '0;
        launch_s    = 1'b0;
        sample_s    = 1'b0;
        rsp_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    // Ready is only raised towards a valid requester, so the
                    // handshake completes whenever a winner exists.
                    req_ready_s[grant_s] = 1'b1;
                    launch_s             = 1'b1;
                    state_n_s            = ST_WAIT;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_r == LAT_ONE) begin
                    sample_s  = 1'b1;
                    state_n_s = ST_RESPOND;
                end else begin
                    state_n_s = ST_WAIT;
                end
            end
            ST_RESPOND: begin
                rsp_valid_s[grant_id_r] = 1'b1;
                if (rsp_ready_in[grant_id_r]) begin
                    rsp_done_s = 1'b1;
                    state_n_s  = ST_IDLE;
                end else begin
                    state_n_s = ST_RESPOND;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Round-robin pointer: advances past the requester whose response completed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_r <= '0;
        end else if (rsp_done_s) begin
            rr_ptr_r <= (grant_id_r == LAST_ID) ? '0 : (grant_id_r + ONE_ID);
        end
    end

    // Launch registers: operands, grant id and latency counter. Operands are
    // held until the next grant so the core sees stable inputs throughout.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcand_r    <= '0;
            mplier_r   <= '0;
            grant_id_r <= '0;
            lat_cnt_r  <= '0;
        end else if (launch_s) begin
            mcand_r    <= req_multiplicand_in[grant_s*WIDTH +: WIDTH];
            mplier_r   <= req_multiplier_in[grant_s*WIDTH +: WIDTH];
            grant_id_r <= grant_s;
            lat_cnt_r  <= LAT_INIT;
        end else if (state_r == ST_WAIT) begin
            lat_cnt_r <= lat_cnt_r - LAT_ONE;
        end
    end

    // Response data capture; holds the last result until the next sample.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            product_r  <= '0;
            overflow_r <= 1'b0;
        end else if (sample_s) begin
            product_r  <= mul_product_in;
            overflow_r <= mul_overflow_in;
        end
    end

`ifdef MULT_ARB_GRANT_COUNT_EN
    logic [16*NUM_REQ-1:0] grant_cnt_r;

    // Per-requester saturating count of completed response handshakes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant_cnt_r <= '0;
        end else if (rsp_done_s) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((grant_id_r == ID_W'(i)) && (grant_cnt_r[i*16 +: 16] != 16'hFFFF)) begin
                    grant_cnt_r[i*16 +: 16] <= grant_cnt_r[i*16 +: 16] + 16'd1;
                end
            end
        end
    end

    assign grant_count_out = grant_cnt_r;
`endif

    // Ready is a combinational grant; it is forced low while reset is asserted
    // so every output reads zero during reset.
    assign req_ready_out        = req_ready_s & {NUM_REQ{reset_n}};
    assign rsp_valid_out        = rsp_valid_s;
    assign rsp_product_out      = product_r;
    assign rsp_overflow_out     = overflow_r;
    assign grant_id_out         = grant_id_r;
    assign busy_out             = (state_r != ST_IDLE);
    assign mul_multiplicand_out = mcand_r;
    assign mul_multiplier_out   = mplier_r;

endmodule

// File: tb/tb_multiplicator_arbiter.sv
// -----------------------------------------------------------------------------
// tb_multiplicator_arbiter
//
// Directed bench for multiplicator_arbiter. Instance dut: WIDTH=8, NUM_REQ=4,
// MUL_LATENCY=1 with a combinational multiplier stub. Instance dut3: WIDTH=8,
// NUM_REQ=3, MUL_LATENCY=3 with a free-running cycle counter as product, used
// for latency alignment and non-power-of-two pointer wrap.
// -----------------------------------------------------------------------------
module tb_multiplicator_arbiter;

    logic        clock;
    logic        reset_n;

    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [15:0] rsp_product;
    logic        rsp_ovf;
    logic [1:0]  grant_id;
    logic        busy;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_p;
    logic        mul_o;

    logic [2:0]  b_req_valid;
    logic [2:0]  b_req_ready;
    logic [23:0] b_mcand;
    logic [23:0] b_mplier;
    logic [2:0]  b_rsp_valid;
    logic [2:0]  b_rsp_ready;
    logic [15:0] b_rsp_product;
    logic        b_rsp_ovf;
    logic [1:0]  b_grant_id;
    logic        b_busy;
    logic [7:0]  b_mul_a;
    logic [7:0]  b_mul_b;
    logic [15:0] cyc;

`ifdef MULT_ARB_GRANT_COUNT_EN
    logic [63:0] gc1;
    logic [47:0] gc3;
`endif

    int checks;
    int errors;

    logic [15:0] prod_exp [4];
    logic        ovf_exp  [4];
    logic [15:0] c0;
    logic [15:0] lat_exp;

    // Multiplier stub: product is combinational on the registered operands.
    assign mul_p = 16'(mul_a) * 16'(mul_b);
    assign mul_o = |mul_p[15:8];

    multiplicator_arbiter #(.WIDTH(8), .NUM_REQ(4), .MUL_LATENCY(1)) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .req_valid_in         (req_valid),
        .req_ready_out        (req_ready),
        .req_multiplicand_in  (mcand),
        .req_multiplier_in    (mplier),
        .rsp_valid_out        (rsp_valid),
        .rsp_ready_in         (rsp_ready),
        .rsp_product_out      (rsp_product),
        .rsp_overflow_out     (rsp_ovf),
        .grant_id_out         (grant_id),
        .busy_out             (busy),
        .mul_multiplicand_out (mul_a),
        .mul_multiplier_out   (mul_b),
        .mul_product_in       (mul_p),
        .mul_overflow_in      (mul_o)
`ifdef MULT_ARB_GRANT_COUNT_EN
        ,
        .grant_count_out      (gc1)
`endif
    );

    multiplicator_arbiter #(.WIDTH(8), .NUM_REQ(3), .MUL_LATENCY(3)) dut3 (
        .clock                (clock),
        .reset_n              (reset_n),
        .req_valid_in         (b_req_valid),
        .req_ready_out        (b_req_ready),
        .req_multiplicand_in  (b_mcand),
        .req_multiplier_in    (b_mplier),
        .rsp_valid_out        (b_rsp_valid),
        .rsp_ready_in         (b_rsp_ready),
        .rsp_product_out      (b_rsp_product),
        .rsp_overflow_out     (b_rsp_ovf),
        .grant_id_out         (b_grant_id),
        .busy_out             (b_busy),
        .mul_multiplicand_out (b_mul_a),
        .mul_multiplier_out   (b_mul_b),
        .mul_product_in       (cyc),
        .mul_overflow_in      (cyc[0])
`ifdef MULT_ARB_GRANT_COUNT_EN
        ,
        .grant_count_out      (gc3)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Free-running stub product for the latency-3 instance.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 16'd0;
        else          cyc <= cyc + 16'd1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        req_valid   = 4'b0000;
        rsp_ready   = 4'b0000;
        mcand       = 32'd0;
        mplier      = 32'd0;
        b_req_valid = 3'b000;
        b_rsp_ready = 3'b000;
        b_mcand     = 24'd0;
        b_mplier    = 24'd0;
        prod_exp[0] = 16'd15;    ovf_exp[0] = 1'b0;
        prod_exp[1] = 16'd240;   ovf_exp[1] = 1'b0;
        prod_exp[2] = 16'd20000; ovf_exp[2] = 1'b1;
        prod_exp[3] = 16'd65025; ovf_exp[3] = 1'b1;

        // Reset state
        #12;
        check_val("rst_req_ready", 32'(req_ready), 32'h0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_val("rst_product",   32'(rsp_product), 32'h0);
        check_val("rst_ovf",       32'(rsp_ovf), 32'h0);
        check_val("rst_grant",     32'(grant_id), 32'h0);
        check_val("rst_busy",      32'(busy), 32'h0);
        check_val("rst_mul_a",     32'(mul_a), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Single request: requester 2, 13 x 11
        mcand[23:16]  = 8'd13;
        mplier[23:16] = 8'd11;
        req_valid     = 4'b0100;
        #1;
        check_val("t1_ready", 32'(req_ready), 32'h4);
        check_val("t1_idle",  32'(busy), 32'h0);
        step();
        req_valid = 4'b0000;
        check_val("t1_busy",  32'(busy), 32'h1);
        check_val("t1_grant", 32'(grant_id), 32'h2);
        check_val("t1_mul_a", 32'(mul_a), 32'd13);
        check_val("t1_mul_b", 32'(mul_b), 32'd11);
        check_val("t1_no_rsp_yet", 32'(rsp_valid), 32'h0);
        step();
        check_val("t1_rsp_valid", 32'(rsp_valid), 32'h4);
        check_val("t1_product",   32'(rsp_product), 32'd143);
        check_val("t1_ovf",       32'(rsp_ovf), 32'h0);
        rsp_ready = 4'b1011;
        step();
        check_val("t1_ignore_other_ready", 32'(rsp_valid), 32'h4);
        rsp_ready = 4'b0100;
        step();
        check_val("t1_done_valid", 32'(rsp_valid), 32'h0);
        check_val("t1_done_busy",  32'(busy), 32'h0);
        rsp_ready = 4'b0000;

        // Round-robin with all four valid, pointer restarted by reset
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n   = 1'b1;
        mcand     = {8'd255, 8'd100, 8'd12, 8'd3};
        mplier    = {8'd255, 8'd200, 8'd20, 8'd5};
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            check_val("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            step();
            check_val("rr_grant", 32'(grant_id), 32'(k % 4));
            check_val("rr_ready_low_wait", 32'(req_ready), 32'h0);
            step();
            check_val("rr_rsp_valid", 32'(rsp_valid), 32'(4'b0001 << (k % 4)));
            check_val("rr_product",   32'(rsp_product), 32'(prod_exp[k % 4]));
            check_val("rr_ovf",       32'(rsp_ovf), 32'(ovf_exp[k % 4]));
            step();
        end

        // Response backpressure on requester 1
        rsp_ready = 4'b1101;
        #1;
        check_val("bp_ready", 32'(req_ready), 32'h2);
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            check_val("bp_rsp_hold",   32'(rsp_valid), 32'h2);
            check_val("bp_prod_hold",  32'(rsp_product), 32'd240);
            check_val("bp_ready_zero", 32'(req_ready), 32'h0);
            step();
        end
        check_val("bp_still_valid", 32'(rsp_valid), 32'h2);
        rsp_ready = 4'b1111;
        step();
        check_val("bp_next_grant", 32'(req_ready), 32'h4);

        // Reset during WAIT
        step();
        check_val("rw_in_wait", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #1;
        check_val("rw_busy",    32'(busy), 32'h0);
        check_val("rw_grant",   32'(grant_id), 32'h0);
        check_val("rw_mul_a",   32'(mul_a), 32'h0);
        check_val("rw_mul_b",   32'(mul_b), 32'h0);
        check_val("rw_product", 32'(rsp_product), 32'h0);
        check_val("rw_rsp",     32'(rsp_valid), 32'h0);
        check_val("rw_ready",   32'(req_ready), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_val("rw_restart_ready", 32'(req_ready), 32'h1);
        check_val("rw_no_stale_rsp",  32'(rsp_valid), 32'h0);
        step();
        step();
        check_val("rw_rsp_valid", 32'(rsp_valid), 32'h1);
        check_val("rw_product2",  32'(rsp_product), 32'd15);
        req_valid = 4'b0000;
        step();
        rsp_ready = 4'b0000;

        // Latency 3 alignment and NUM_REQ=3 wrap on dut3
        b_req_valid = 3'b100;
        b_rsp_ready = 3'b111;
        #1;
        check_val("l3_ready", 32'(b_req_ready), 32'h4);
        step();
        b_req_valid = 3'b111;
        c0 = cyc;
        check_val("l3_wait0", 32'(b_rsp_valid), 32'h0);
        step();
        check_val("l3_wait1", 32'(b_rsp_valid), 32'h0);
        step();
        check_val("l3_wait2", 32'(b_rsp_valid), 32'h0);
        step();
        lat_exp = c0 + 16'd2;
        check_val("l3_rsp_valid", 32'(b_rsp_valid), 32'h4);
        check_val("l3_product",   32'(b_rsp_product), 32'(lat_exp));
        check_val("l3_ovf",       32'(b_rsp_ovf), 32'(lat_exp[0]));
        step();
        check_val("l3_wrap_ready", 32'(b_req_ready), 32'h1);
        b_req_valid = 3'b000;
        step();
        check_val("l3_idle", 32'(b_busy), 32'h0);

`ifdef MULT_ARB_GRANT_COUNT_EN
        // Grant counters: three completions for requester 1, then saturation
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_val("gc_reset", gc1[31:0], 32'h0);
        rsp_ready = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'b0010;
            step();
            req_valid = 4'b0000;
            step();
            step();
        end
        check_val("gc_req1_three", 32'(gc1[31:16]), 32'd3);
        check_val("gc_req0_zero",  32'(gc1[15:0]), 32'd0);
        force dut.grant_cnt_r = {32'h0, 16'hFFFF, 16'h0};
        #1;
        release dut.grant_cnt_r;
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0000;
        step();
        step();
        check_val("gc_saturate", 32'(gc1[31:16]), 32'h0000FFFF);
        rsp_ready = 4'b0000;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
